// File: rtl/hnf_pocq_mc.sv
// hnf_pocq_mc: multi-channel HN-F point-of-coherency queue with oldest-first pop tracked by an age matrix.
// Optional high-water-mark tracking is enabled by defining POCQ_HWM_EN.
module hnf_pocq_mc #(
  parameter int WIDTH  = 128,
  parameter int DEPTH  = 16,
  parameter int NUM_CH = 2,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int CH_W   = ($clog2(NUM_CH) > 0 ? $clog2(NUM_CH) : 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       push_valid,
  output logic [NUM_CH-1:0]       push_ready,
  input  logic [NUM_CH*WIDTH-1:0] push_data,
  output logic                    pop_valid,
  input  logic                    pop_ready,
  output logic [WIDTH-1:0]        pop_data,
  output logic [CH_W-1:0]         pop_ch,
  output logic [IDX_W-1:0]        pop_idx,
  output logic [IDX_W:0]          occupancy,
  output logic                    pocq_is_empty,
  output logic                    pocq_is_full
`ifdef POCQ_HWM_EN
  ,
  input  logic                    hwm_clr,
  output logic [IDX_W:0]          hwm
`endif
);

  logic [DEPTH-1:0] valid_p1;
  logic [DEPTH-1:0] age_p1 [DEPTH];
  logic [WIDTH-1:0] data_p1 [DEPTH];
  logic [CH_W-1:0]  ch_p1 [DEPTH];
  logic [IDX_W:0]   occ_p1;

  logic [IDX_W:0]   free_slots;
  logic [IDX_W:0]   req_cnt;
  logic [IDX_W:0]   acc_cnt;
  logic [NUM_CH-1:0] push_acc;
  logic [DEPTH-1:0] alloc_mask;
  logic [CH_W-1:0]  alloc_ch [DEPTH];
  logic             found;
  logic [DEPTH-1:0] oldest;
  logic             pop_fire;
  logic [IDX_W:0]   occ_nxt;
  logic [WIDTH-1:0] push_word [NUM_CH];

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      push_word[c] = push_data[c*WIDTH +: WIDTH];
    end
  end

  // Admission uses the registered count only, so a same-cycle pop never frees a slot early
  always_comb begin
    free_slots = (IDX_W+1)'(DEPTH) - occ_p1;
    req_cnt    = '0;
    push_ready = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      push_ready[c] = (req_cnt < free_slots);
      if (push_valid[c]) req_cnt = req_cnt + (IDX_W+1)'(1);
    end
  end

  always_comb begin
    push_acc   = push_valid & push_ready;
    acc_cnt    = '0;
    alloc_mask = '0;
    found      = 1'b0;
    for (int s = 0; s < DEPTH; s++) alloc_ch[s] = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (push_acc[c]) begin
        acc_cnt = acc_cnt + (IDX_W+1)'(1);
        found   = 1'b0;
        for (int s = 0; s < DEPTH; s++) begin
          if (!found && !valid_p1[s] && !alloc_mask[s]) begin
            alloc_mask[s] = 1'b1;
            alloc_ch[s]   = CH_W'(c);
            found         = 1'b1;
          end
        end
      end
    end
  end

  // Oldest entry: valid with no valid entry marked older than it
  always_comb begin
    oldest = '0;
    for (int i = 0; i < DEPTH; i++) begin
      oldest[i] = valid_p1[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (valid_p1[j] && age_p1[j][i]) oldest[i] = 1'b0;
      end
    end
  end

  always_comb begin
    pop_valid = |valid_p1;
    pop_data  = '0;
    pop_ch    = '0;
    pop_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (oldest[i]) begin
        pop_data = pop_data | data_p1[i];
        pop_ch   = pop_ch | ch_p1[i];
        pop_idx  = pop_idx | IDX_W'(i);
      end
    end
  end

  assign pop_fire      = pop_valid & pop_ready;
  assign occ_nxt       = occ_p1 + acc_cnt - {{IDX_W{1'b0}}, pop_fire};
  assign occupancy     = occ_p1;
  assign pocq_is_empty = (occ_p1 == '0);
  assign pocq_is_full  = (occ_p1 == (IDX_W+1)'(DEPTH));

  // Stage p1: queue state; a new entry is younger than every resident and lower channels win ties
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_p1 <= '0;
      occ_p1   <= '0;
      for (int i = 0; i < DEPTH; i++) age_p1[i] <= '0;
    end else begin
      valid_p1 <= (valid_p1 & ~(oldest & {DEPTH{pop_fire}})) | alloc_mask;
      occ_p1   <= occ_nxt;
      for (int s = 0; s < DEPTH; s++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (alloc_mask[s]) begin
            age_p1[s][j] <= alloc_mask[j] && (alloc_ch[j] > alloc_ch[s]);
          end else if (alloc_mask[j]) begin
            age_p1[s][j] <= valid_p1[s];
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int s = 0; s < DEPTH; s++) begin
      if (alloc_mask[s]) begin
        data_p1[s] <= push_word[alloc_ch[s]];
        ch_p1[s]   <= alloc_ch[s];
      end
    end
  end

`ifdef POCQ_HWM_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      hwm <= '0;
    end else if (hwm_clr) begin
      hwm <= occ_p1;
    end else if (occ_nxt > hwm) begin
      hwm <= occ_nxt;
    end
  end
`endif

  a_oldest_onehot: assert property (@(posedge clock) disable iff (reset)
    pop_valid |-> $onehot(oldest));

endmodule
